// File: rtl/mine_field_gen.sv
// mine_field_gen: places NUM_MINES mines off the first-click tile, then scans per-tile neighbour counts.
// Define SAFE_ZONE_EN to keep the whole 3x3 around the first click mine-free.
module mine_field_gen #(
  parameter int GRID_SIZE = 8,
  parameter int NUM_MINES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
  localparam int IB = $clog2(TOTAL_TILES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [IB-1:0]            start_index_i,
  output logic [TOTAL_TILES-1:0]   mine_map_o,
  output logic [TOTAL_TILES*4-1:0] adj_o,
  output logic                     game_ready_o,
  output logic                     busy_o
);
  localparam int RB = $clog2(GRID_SIZE);
  localparam int PB = $clog2(NUM_MINES + 1);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  typedef enum logic [1:0] {IDLE, PLACE, COUNT, READY} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q;
  logic [IB-1:0] safe_q, safe_d, idx_q, idx_d, cand;
  logic [RB-1:0] row_q, row_d, col_q, col_d;
  logic [PB-1:0] placed_q, placed_d;
  logic [TOTAL_TILES-1:0] map_q, map_d;
  logic [TOTAL_TILES*4-1:0] adj_q, adj_d;
  logic near, reject, last_col;
  logic [3:0] nsum;
  int nr, nc;
  assign cand = lfsr_q[IB-1:0];
  assign last_col = col_q == RB'(GRID_SIZE - 1);
`ifdef SAFE_ZONE_EN
  int dr, dc;
  always_comb begin
    dr = int'(cand) / GRID_SIZE - int'(safe_q) / GRID_SIZE;
    dc = int'(cand) % GRID_SIZE - int'(safe_q) % GRID_SIZE;
    near = dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1;
  end
`else
  assign near = cand == safe_q;
`endif
  assign reject = ({1'b0, cand} >= (IB+1)'(TOTAL_TILES)) || near || map_q[cand];
  // Neighbour sum for the tile under scan, bounds-checked so edges never wrap.
  always_comb begin
    nsum = '0;
    nr = 0;
    nc = 0;
    for (int r = -1; r <= 1; r++)
      for (int c = -1; c <= 1; c++) begin
        nr = int'(row_q) + r;
        nc = int'(col_q) + c;
        if (!(r == 0 && c == 0) && nr >= 0 && nr < GRID_SIZE && nc >= 0 && nc < GRID_SIZE)
          nsum = nsum + 4'(map_q[IB'(nr * GRID_SIZE + nc)]);
      end
  end
  always_comb begin
    state_d = state_q;
    safe_d = safe_q;
    placed_d = placed_q;
    idx_d = idx_q;
    row_d = row_q;
    col_d = col_q;
    map_d = map_q;
    adj_d = adj_q;
    if (state_q == IDLE && start_i) begin
      state_d = PLACE;
      placed_d = '0;
      safe_d = ({1'b0, start_index_i} >= (IB+1)'(TOTAL_TILES)) ? IB'(TOTAL_TILES - 1) : start_index_i;
    end
    if (state_q == PLACE && !reject) begin
      map_d[cand] = 1'b1;
      placed_d = placed_q + 1'b1;
      if (placed_q == PB'(NUM_MINES - 1)) begin
        state_d = COUNT;
        idx_d = '0;
        row_d = '0;
        col_d = '0;
      end
    end
    if (state_q == COUNT) begin
      adj_d[idx_q*4 +: 4] = map_q[idx_q] ? 4'hF : nsum;
      idx_d = idx_q + 1'b1;
      col_d = last_col ? '0 : col_q + 1'b1;
      row_d = last_col ? row_q + 1'b1 : row_q;
      state_d = (idx_q == IB'(TOTAL_TILES - 1)) ? READY : COUNT;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q <= SEED;
      safe_q <= '0;
      placed_q <= '0;
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
      map_q <= '0;
      adj_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      safe_q <= safe_d;
      placed_q <= placed_d;
      idx_q <= idx_d;
      row_q <= row_d;
      col_q <= col_d;
      map_q <= map_d;
      adj_q <= adj_d;
    end
  end
  assign mine_map_o = map_q;
  assign adj_o = adj_q;
  assign game_ready_o = state_q == READY;
  assign busy_o = state_q == PLACE || state_q == COUNT;
endmodule

// File: tb/tb_mine_field_gen.sv
// tb_mine_field_gen: directed first-click runs checked against a placement/adjacency model.
module tb_mine_field_gen;
  logic clk = 0, rst = 0, start_i = 0;
  logic [5:0] start_index_i = '0;
  logic [63:0] mine_map_o;
  logic [255:0] adj_o;
  logic game_ready_o, busy_o;
  int n_run = 0, n_fail = 0;
  logic [15:0] m_lfsr;
  logic [63:0] map2, mapx, map5;
  logic [255:0] adj2;
  int p2, lat2, px, latx, p5, lat5;
  always #5 clk = ~clk;
  mine_field_gen dut (
    .clk(clk), .rst(rst), .start_i(start_i), .start_index_i(start_index_i),
    .mine_map_o(mine_map_o), .adj_o(adj_o), .game_ready_o(game_ready_o), .busy_o(busy_o)
  );
  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction
  always @(posedge clk or negedge rst)
    if (!rst) m_lfsr <= 16'hACE1;
    else m_lfsr <= nxt(m_lfsr);
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model_place(input logic [15:0] l0, input int safe, output logic [63:0] map, output int p);
    logic [15:0] l;
    int placed, cand;
    bit near;
    l = l0;
    placed = 0;
    map = '0;
    p = 0;
    while (placed < 10 && p < 200000) begin
      l = nxt(l);
      p++;
      cand = int'(l[5:0]);
`ifdef SAFE_ZONE_EN
      near = (cand / 8 - safe / 8) >= -1 && (cand / 8 - safe / 8) <= 1 &&
             (cand % 8 - safe % 8) >= -1 && (cand % 8 - safe % 8) <= 1;
`else
      near = cand == safe;
`endif
      if (!near && !map[cand]) begin
        map[cand] = 1'b1;
        placed++;
      end
    end
  endfunction
  function automatic logic [255:0] model_adj(input logic [63:0] map);
    logic [255:0] a;
    int n, r, c;
    a = '0;
    for (int i = 0; i < 64; i++) begin
      r = i / 8;
      c = i % 8;
      n = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
            n += int'(map[(r + dr) * 8 + c + dc]);
      a[i*4 +: 4] = map[i] ? 4'hF : 4'(n);
    end
    return a;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    rst = 1;
  endtask
  task automatic run(input int w, input logic [5:0] idx, input bit extra, input int abort_at,
                     output logic [63:0] map, output int p, output int lat);
    repeat (w) @(negedge clk);
    start_i = 1;
    start_index_i = idx;
    model_place(m_lfsr, int'(idx), map, p);
    @(negedge clk);
    start_i = 0;
    check("busy_rise", busy_o, 1);
    check("ready_low_early", game_ready_o, 0);
    lat = 1;
    while (!game_ready_o && lat < 3000 && !(abort_at > 0 && lat == p + abort_at)) begin
      start_i = extra && lat == 3;
      start_index_i = 6'd5;
      @(negedge clk);
      start_i = 0;
      lat++;
    end
    if (abort_at == 0) check("ready_timeout", lat < 3000, 1);
  endtask
  initial begin
    // T1: reset state, then idle
    rst = 0;
    repeat (2) @(negedge clk);
    check("rst_map", mine_map_o, 0);
    check("rst_adj", adj_o, 0);
    check("rst_ready", game_ready_o, 0);
    check("rst_busy", busy_o, 0);
    do_reset();
    repeat (100) @(negedge clk);
    check("idle_map", mine_map_o, 0);
    check("idle_adj", adj_o, 0);
    check("idle_ready", game_ready_o, 0);
    check("idle_busy", busy_o, 0);
    // T2: start at 27
    run(0, 6'd27, 0, 0, map2, p2, lat2);
    check("lat_exact", lat2, p2 + 65);
    check("lat_min", lat2 >= 75, 1);
    check("popcount", $countones(mine_map_o), 10);
    check("safe_27", mine_map_o[27], 0);
    check("map_model", mine_map_o, map2);
    check("ready_busy", busy_o, 0);
    repeat (5) @(negedge clk);
    check("ready_hold", game_ready_o, 1);
    // T3: adjacency
    adj2 = model_adj(map2);
    check("adj_model", adj_o, adj2);
    check("adj_tile0", adj_o[3:0], adj2[3:0]);
    check("adj_tile7", adj_o[31:28], adj2[31:28]);
`ifdef SAFE_ZONE_EN
    check("zone_27", {mine_map_o[36:34], mine_map_o[28:26], mine_map_o[20:18]}, 0);
    check("adj_27_zero", adj_o[27*4 +: 4], 0);
`endif
    // T4: identical timing with stray start pulses mid-PLACE and in READY
    do_reset();
    repeat (100) @(negedge clk);
    run(0, 6'd27, 1, 0, mapx, px, latx);
    start_i = 1;
    start_index_i = 6'd5;
    @(negedge clk);
    start_i = 0;
    repeat (3) @(negedge clk);
    check("t4_map", mine_map_o, map2);
    check("t4_adj", adj_o, adj2);
    check("t4_lat", latx, lat2);
    check("t4_ready", game_ready_o, 1);
    check("t4_busy", busy_o, 0);
    // T5: reset mid-COUNT, then restart at 0
    do_reset();
    run(37, 6'd27, 0, 10, mapx, px, latx);
    check("t5_in_count", busy_o, 1);
    check("t5_partial_map", mine_map_o, mapx);
    rst = 0;
    #1;
    check("t5_rst_map", mine_map_o, 0);
    check("t5_rst_adj", adj_o, 0);
    check("t5_rst_ready", game_ready_o, 0);
    check("t5_rst_busy", busy_o, 0);
    @(negedge clk);
    rst = 1;
    run(13, 6'd0, 0, 0, map5, p5, lat5);
    check("t5_lat", lat5, p5 + 65);
    check("t5_map", mine_map_o, map5);
    check("t5_safe0", mine_map_o[0], 0);
    check("t5_popcount", $countones(mine_map_o), 10);
    check("t5_adj", adj_o, model_adj(map5));
`ifdef SAFE_ZONE_EN
    check("zone_0", {mine_map_o[9:8], mine_map_o[1:0]}, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
